mul_err_sweep: RTL and testbench

MUL_ERR_SWEEP -- requirements
Module: mul_err_sweep

---
 rtl/mul_err_pkg.sv | 25 ++
 rtl/err_metric_acc.sv | 56 +++++
 rtl/mul_err_sweep.sv | 110 +++++++++++
 tb/tb_mul_err_sweep.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_err_pkg.sv
// rtl/mul_err_pkg.sv - shared types and sizes for the exhaustive multiplier error sweep
package mul_err_pkg;

    localparam int OP_W    = 6;
    localparam int PROD_W  = 12;
    localparam int IDX_W   = 2 * OP_W;
    localparam int NUM_VEC = 4096;
    localparam int CNT_W   = 13;   // holds NUM_VEC itself
    localparam int SUM_W   = 24;   // holds NUM_VEC * (2^PROD_W - 1)

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [PROD_W-1:0] abs_diff(
        input logic [PROD_W-1:0] a,
        input logic [PROD_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/err_metric_acc.sv
// rtl/err_metric_acc.sv - accumulates error metrics from registered sweep results
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear             zero all metrics (new sweep accepted)
//   valid             one result to fold in this edge
//   exact, approx     reference and DUT products
//   idx               vector index {op_b, op_a} of this result
//   err_count         mismatching vectors
//   max_err, sum_err  largest and total absolute error
//   first_err_idx/vld index of first mismatch and its capture flag
module err_metric_acc
    import mul_err_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              valid,
    input  logic [PROD_W-1:0] exact,
    input  logic [PROD_W-1:0] approx,
    input  logic [IDX_W-1:0]  idx,
    output logic [CNT_W-1:0]  err_count,
    output logic [PROD_W-1:0] max_err,
    output logic [SUM_W-1:0]  sum_err,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic              first_err_vld
);

    logic [PROD_W-1:0] diff;
    logic              mism;

    assign diff = abs_diff(exact, approx);
    assign mism = (exact != approx);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_count     <= '0;
            max_err       <= '0;
            sum_err       <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else if (valid && mism) begin
            err_count <= err_count + 1'b1;
            sum_err   <= sum_err + SUM_W'(diff);
            if (diff > max_err) begin
                max_err <= diff;
            end
            // Only the earliest mismatch of a sweep is recorded.
            if (!first_err_vld) begin
                first_err_idx <= idx;
                first_err_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_err_sweep.sv
// rtl/mul_err_sweep.sv - drives all 4096 6x6 operand pairs into an external multiplier and scores its error
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a sweep (taken only in IDLE)
//   hold              freeze counter, pipeline and FSM
//   op_a, op_b        operands to the external multiplier (zero outside SWEEP)
//   dut_p             product returned combinationally by the multiplier
//   busy, done        SWEEP/DRAIN indicator, final-metrics strobe
//   err_count, max_err, sum_err, first_err_idx, first_err_vld  sweep metrics
module mul_err_sweep
    import mul_err_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic [OP_W-1:0]   op_a,
    output logic [OP_W-1:0]   op_b,
    input  logic [PROD_W-1:0] dut_p,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic [PROD_W-1:0] max_err,
    output logic [SUM_W-1:0]  sum_err,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic              first_err_vld
);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [PROD_W-1:0] exact_p;

    logic              s1_valid;
    logic [IDX_W-1:0]  s1_idx;
    logic [PROD_W-1:0] s1_exact;
    logic [PROD_W-1:0] s1_dut;

    logic              accept;

    // idx is held at zero outside SWEEP, so the operands need no extra gating.
    assign op_a    = idx[OP_W-1:0];
    assign op_b    = idx[IDX_W-1:OP_W];
    assign exact_p = PROD_W'(op_a) * PROD_W'(op_b);
    assign accept  = (state == IDLE) && start && !hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_exact <= '0;
            s1_dut   <= '0;
        end else if (!hold) begin
            s1_valid <= (state == SWEEP);
            s1_idx   <= idx;
            s1_exact <= exact_p;
            s1_dut   <= dut_p;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SWEEP;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    // Last vector wraps idx back to zero for the idle operands.
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(NUM_VEC - 1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Final vector is folded in at this edge, so metrics are final next cycle.
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    err_metric_acc u_acc (
        .clk           (clk),
        .rst           (rst),
        .clear         (accept),
        .valid         (s1_valid && !hold),
        .exact         (s1_exact),
        .approx        (s1_dut),
        .idx           (s1_idx),
        .err_count     (err_count),
        .max_err       (max_err),
        .sum_err       (sum_err),
        .first_err_idx (first_err_idx),
        .first_err_vld (first_err_vld)
    );

endmodule

// File: tb/tb_mul_err_sweep.sv
// tb/tb_mul_err_sweep.sv - self-checking bench for mul_err_sweep
module tb_mul_err_sweep;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hold;
    logic [5:0]  op_a;
    logic [5:0]  op_b;
    logic [11:0] dut_p;
    logic        busy;
    logic        done;
    logic [12:0] err_count;
    logic [11:0] max_err;
    logic [23:0] sum_err;
    logic [11:0] first_err_idx;
    logic        first_err_vld;

    int mode;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          mode;
        int          hold_at;
        int          hold_len;
        int          exp_done;
        logic [12:0] ec;
        logic [11:0] me;
        logic [23:0] se;
        logic [11:0] fi;
        logic        fv;
    } vec_t;

    vec_t vecs[7];
    vec_t sbq[$];

    always #5 clk = ~clk;

    mul_err_sweep dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .hold          (hold),
        .op_a          (op_a),
        .op_b          (op_b),
        .dut_p         (dut_p),
        .busy          (busy),
        .done          (done),
        .err_count     (err_count),
        .max_err       (max_err),
        .sum_err       (sum_err),
        .first_err_idx (first_err_idx),
        .first_err_vld (first_err_vld)
    );

    // Multiplier models standing in for the external DUT.
    logic [11:0] prod;
    always_comb begin
        prod = {6'd0, op_a} * {6'd0, op_b};
        case (mode)
            0: dut_p = prod;
            1: dut_p = prod & 12'hffe;
            2: dut_p = 12'd0;
            3: dut_p = prod + ((op_a == op_b) ? 12'd3 : 12'd0);
            4: dut_p = (op_a == 6'd63 && op_b == 6'd63) ? 12'd0 : prod;
            default: dut_p = prod;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_op_a"}, 32'(op_a), 0);
        chk({tag, "_op_b"}, 32'(op_b), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err_count"}, 32'(err_count), 0);
        chk({tag, "_max_err"}, 32'(max_err), 0);
        chk({tag, "_sum_err"}, 32'(sum_err), 0);
        chk({tag, "_first_idx"}, 32'(first_err_idx), 0);
        chk({tag, "_first_vld"}, 32'(first_err_vld), 0);
    endtask

    task automatic chk_metrics(input string tag, input vec_t e);
        chk({tag, "_err_count"}, 32'(err_count), 32'(e.ec));
        chk({tag, "_max_err"}, 32'(max_err), 32'(e.me));
        chk({tag, "_sum_err"}, 32'(sum_err), 32'(e.se));
        chk({tag, "_first_vld"}, 32'(first_err_vld), 32'(e.fv));
        if (e.fv) chk({tag, "_first_idx"}, 32'(first_err_idx), 32'(e.fi));
    endtask

    // Start in cycle 0, run until done, compare against the scoreboard entry.
    task automatic run_sweep(input vec_t v);
        int   cyc;
        bit   got;
        vec_t e;
        mode  = v.mode;
        start = 1'b1;
        sbq.push_back(v);
        step();
        start = 1'b0;
        cyc = 1;
        got = 0;
        while (!got && cyc < 6000) begin
            hold = (v.hold_len > 0) && (cyc >= v.hold_at) && (cyc < v.hold_at + v.hold_len);
            if (cyc == 1) begin
                chk("sweep_busy_c1", 32'(busy), 1);
                chk("sweep_op_c1", 32'({op_b, op_a}), 0);
            end
            if (cyc == 2) chk("sweep_op_c2", 32'({op_b, op_a}), 1);
            if (done) begin
                got = 1;
                e = sbq.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.exp_done));
                chk_metrics("sweep", e);
                hold = 1'b0;
                step();
                chk("done_pulse", 32'(done), 0);
                chk("idle_busy", 32'(busy), 0);
                chk("stable_err_count", 32'(err_count), 32'(e.ec));
            end else begin
                step();
                cyc++;
            end
        end
        if (!got) begin
            chk("done_timeout", 0, 1);
            void'(sbq.pop_front());
            hold = 1'b0;
        end
    endtask

    initial begin
        int   cyc;
        int   ndone;
        int   done_at;
        vec_t v1;

        //            mode hold_at len done   ec    me    se       fi    fv
        vecs[0] = '{1, 0,    0,  4098, 1024, 1,    1024,    65,   1};
        vecs[1] = '{2, 0,    0,  4098, 3969, 3969, 4064256, 65,   1};
        vecs[2] = '{3, 0,    0,  4098, 64,   3,    192,     0,    1};
        vecs[3] = '{4, 0,    0,  4098, 1,    3969, 3969,    4095, 1};
        vecs[4] = '{0, 0,    0,  4098, 0,    0,    0,       0,    0};
        vecs[5] = '{0, 2000, 10, 4108, 0,    0,    0,       0,    0};
        vecs[6] = '{1, 4097, 3,  4101, 1024, 1,    1024,    65,   1};

        mode  = 0;
        rst   = 1'b1;
        start = 1'b1;
        hold  = 1'b1;
        step();
        step();
        chk_zero("reset");
        rst   = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        step();
        chk_zero("idle");

        for (int i = 0; i < 7; i++) run_sweep(vecs[i]);

        // Reset in cycle 1000 of a sweep aborts it.
        mode  = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 1000; c++) step();
        chk("pre_rst_err_count_nonzero", 32'(err_count != 0), 1);
        rst = 1'b1;
        step();
        chk_zero("mid_rst");
        rst = 1'b0;
        step();
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_op", 32'({op_b, op_a}), 0);

        // Start pulses during the sweep and in the DONE cycle are ignored.
        v1 = vecs[0];
        mode  = 1;
        start = 1'b1;
        sbq.push_back(v1);
        step();
        start   = 1'b0;
        ndone   = 0;
        done_at = -1;
        for (int c = 1; c < 4200; c++) begin
            start = (c == 500) || (c == 4098);
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            step();
        end
        start = 1'b0;
        v1 = sbq.pop_front();
        chk("ign_done_count", 32'(ndone), 1);
        chk("ign_done_cycle", 32'(done_at), 32'(v1.exp_done));
        chk("ign_busy", 32'(busy), 0);
        chk_metrics("ign", v1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
